pair_range: RTL and testbench

//   Hardware generator for: i=base; n=0; while i in range(base,limit,step): yield (i, n); i+=step; n+=1.

---
 rtl/pair_range.sv | 87 ++++++++
 tb/tb_pair_range.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pair_range.sv
// Range generator: emits (i, n) for i = base, base+step, ... while i stays inside
// [base, limit) (or (limit, base] for negative step), one tuple per valid/ready handshake.
module pair_range #(
    parameter int WIDTH = 32
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             _ready,
    output logic             _valid,
    output logic             _done,
    output logic [WIDTH-1:0] _0,
    output logic [WIDTH-1:0] _1
);

    typedef enum logic {S_DONE, S_RUN} state_t;

    localparam logic signed [WIDTH-1:0] ZERO = '0;

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] i_q, lim_q, stp_q;
    logic        [WIDTH-1:0] n_q;
    logic                    ovf_q;
    logic                    adv, in_range, emit;
    logic        [WIDTH:0]   sum;
    logic                    sum_ovf;

    // Sign-extended sum; top two bits disagreeing means i+stp left the signed range.
    assign sum     = {i_q[WIDTH-1], i_q} + {stp_q[WIDTH-1], stp_q};
    assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

    assign adv      = _ready || !_valid;
    assign in_range = !ovf_q && (((stp_q > ZERO) && (i_q < lim_q)) ||
                                 ((stp_q < ZERO) && (i_q > lim_q)));

    // State register: start outranks reset.
    always_ff @(posedge _clock) begin
        if (_start)
            state <= S_RUN;
        else if (_reset)
            state <= S_DONE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (adv && !in_range) state_nxt = S_DONE;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        _done = (state == S_DONE);
        emit  = (state == S_RUN) && adv && in_range;
    end

    always_ff @(posedge _clock) begin
        if (_start) begin
            lim_q  <= limit;
            stp_q  <= step;
            i_q    <= base;
            n_q    <= '0;
            ovf_q  <= 1'b0;
            _valid <= 1'b0;
        end else if (_reset) begin
            _valid <= 1'b0;
            _0     <= '0;
            _1     <= '0;
        end else begin
            if (_ready) _valid <= 1'b0;
            if (emit) begin
                _0     <= i_q;
                _1     <= n_q;
                _valid <= 1'b1;
                i_q    <= sum[WIDTH-1:0];
                n_q    <= n_q + 1'b1;
                ovf_q  <= sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pair_range.sv
// Bench for pair_range: fixed vector table, hand-written corner sequences and
// randomized ranges checked against a wide-integer reference model.
module tb_pair_range;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [31:0] base, limit, step;
    logic        valid, done;
    logic [31:0] o0, o1;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_v[$], exp_n[$], got_v[$], got_n[$];

    always #5 clk = ~clk;

    pair_range #(.WIDTH(32)) dut (
        ._clock(clk), ._reset(rst), ._start(start),
        .base(base), .limit(limit), .step(step),
        ._ready(ready), ._valid(valid), ._done(done),
        ._0(o0), ._1(o1)
    );

    typedef struct {
        logic [31:0] b, l, s;
        int          rmode;   // 0: ready high, 1: pattern 1,0,0, 2: random
        int          cnt;
        logic [31:0] last_v;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the range in 64-bit arithmetic, stop at the bound or when i leaves int32.
    task automatic model(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
        longint i, lim, st;
        logic [31:0] n;
        i = longint'($signed(b)); lim = longint'($signed(l)); st = longint'($signed(s));
        n = 0;
        exp_v.delete(); exp_n.delete();
        while (((st > 0 && i < lim) || (st < 0 && i > lim)) && exp_v.size() < 1000) begin
            exp_v.push_back(i[31:0]);
            exp_n.push_back(n);
            i = i + st;
            n = n + 1;
            if (i > 64'sd2147483647 || i < -64'sd2147483648) break;
        end
    endtask

    // Entered just after a negedge; leaves just after the negedge following the start edge.
    task automatic do_start(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
        start = 1'b1; base = b; limit = l; step = s;
        @(negedge clk);
        start = 1'b0;
        chk("start_valid", {63'd0, valid}, 64'd0);
        chk("start_done", {63'd0, done}, 64'd0);
    endtask

    task automatic collect(input int rmode);
        int   cyc, last_acc;
        logic r, hold;
        logic [31:0] pv, pn;
        got_v.delete(); got_n.delete();
        cyc = 0; last_acc = -1; hold = 1'b0; pv = 0; pn = 0;
        while (cyc < 600) begin
            if (hold) begin
                chk("hold_valid", {63'd0, valid}, 64'd1);
                chk("hold_data", {o0, o1}, {pv, pn});
            end
            if (valid && done) chk("done_and_valid", 64'd1, 64'd0);
            if (done) break;
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            if (valid && r) begin
                got_v.push_back(o0); got_n.push_back(o1); last_acc = cyc;
            end
            hold = valid && !r; pv = o0; pn = o1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 600) chk("timeout", 64'd1, 64'd0);
        else if (last_acc >= 0) chk("done_latency", 64'(cyc - last_acc), 64'd1);
        else chk("empty_done_latency", 64'(cyc), 64'd1);
        ready = 1'b0;
    endtask

    task automatic compare(input string nm);
        chk({nm, "_count"}, 64'(got_v.size()), 64'(exp_v.size()));
        for (int k = 0; k < got_v.size() && k < exp_v.size(); k++)
            chk({nm, "_tuple"}, {got_v[k], got_n[k]}, {exp_v[k], exp_n[k]});
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'd0, 32'd10, 32'd2, 0, 5, 32'd8};
        vecs[1] = '{32'd0, 32'd10, 32'd2, 1, 5, 32'd8};
        vecs[2] = '{32'd10, 32'd0, -32'sd3, 0, 4, 32'd1};
        vecs[3] = '{32'd5, 32'd5, 32'd1, 0, 0, 32'd0};
        vecs[4] = '{32'd5, 32'd5, 32'd0, 0, 0, 32'd0};
        vecs[5] = '{32'h7FFFFFFD, 32'h7FFFFFFF, 32'd4, 0, 1, 32'h7FFFFFFD};
        vecs[6] = '{-32'sd5, 32'd5, 32'd3, 2, 4, 32'd4};
        vecs[7] = '{32'h80000002, 32'h80000000, -32'sd1, 0, 2, 32'h80000001};
        vecs[8] = '{32'h80000003, 32'h80000000, -32'sd5, 2, 1, 32'h80000003};

        rst = 1'b1; start = 1'b0; ready = 1'b0; base = 0; limit = 0; step = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd1);
        chk("rst_out", {o0, o1}, 64'd0);
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("idle_done", {62'd0, done, valid}, 64'd2);
        ready = 1'b0;

        foreach (vecs[v]) begin
            do_start(vecs[v].b, vecs[v].l, vecs[v].s);
            model(vecs[v].b, vecs[v].l, vecs[v].s);
            collect(vecs[v].rmode);
            compare("vec");
            chk("vec_cnt", 64'(got_v.size()), 64'(vecs[v].cnt));
            if (vecs[v].cnt > 0 && got_v.size() > 0)
                chk("vec_last", {32'd0, got_v[got_v.size()-1]}, {32'd0, vecs[v].last_v});
        end

        // Reset after two tuples, then start and reset on the same edge.
        do_start(32'd0, 32'd10, 32'd2);
        ready = 1'b1;
        @(negedge clk);
        chk("t5_t0", {31'd0, valid, o0, o1}, {31'd0, 1'b1, 32'd0, 32'd0});
        @(negedge clk);
        chk("t5_t1", {31'd0, valid, o0, o1}, {31'd0, 1'b1, 32'd2, 32'd1});
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst", {30'd0, valid, done, o0, o1}, {30'd0, 2'b01, 64'd0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("t5_restart", {62'd0, valid, done}, 64'd0);
        @(negedge clk);
        chk("t5_first", {31'd0, valid, o0, o1}, {31'd0, 1'b1, 32'd0, 32'd0});

        // Restart while a tuple is pending under backpressure.
        ready = 1'b0;
        do_start(32'd0, 32'd10, 32'd2);
        @(negedge clk);
        chk("t6_pending", {31'd0, valid, o0}, {31'd0, 1'b1, 32'd0});
        do_start(32'd100, 32'd103, 32'd1);
        model(32'd100, 32'd103, 32'd1);
        collect(0);
        compare("t6");

        for (int t = 0; t < 40; t++) begin
            longint b, s, l, cnt;
            if ($urandom_range(0, 4) == 0)
                b = ($urandom_range(0, 1) != 0) ? 64'sd2147483647 - longint'($urandom_range(0, 60))
                                                : -64'sd2147483648 + longint'($urandom_range(0, 60));
            else
                b = longint'($urandom_range(0, 2000)) - 1000;
            s   = longint'($urandom_range(0, 40)) - 20;
            cnt = longint'($urandom_range(0, 30));
            l   = b + s * cnt + longint'($urandom_range(0, 4)) - 2;
            if (l > 64'sd2147483647) l = 64'sd2147483647;
            if (l < -64'sd2147483648) l = -64'sd2147483648;
            do_start(b[31:0], l[31:0], s[31:0]);
            model(b[31:0], l[31:0], s[31:0]);
            collect(2);
            compare("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
